alu_seq_hs: RTL and testbench

Parametrised sequential ALU and successor to the 16-bit combinational ALU. It keeps the same 16-opcode set and the enable input. It adds a registered output, a valid/ready handshake on both input and output, status flags, and iterative multi-cycle multiply and divide. It sits between an operand-issuing controller and a result consumer in the datapath.

---
 rtl/alu_seq_hs.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq_hs.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_hs.sv
// Sequential ALU with valid/ready handshake, status flags and
// iterative shift-add multiply / restoring divide.
module alu_seq_hs #(
   parameter  int WIDTH = 16,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] aux,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_dz
);

   localparam int MSB = WIDTH - 1;
   localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t           r_state, w_next, w_acc_st;
   logic             w_acc;
   logic [SHW:0]     r_cnt;
   logic [WIDTH-1:0] r_b, r_hi, r_lo, r_res, r_aux;
   logic             r_z, r_n, r_c, r_v, r_dz;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_c, w_v;
   logic [SHW-1:0]   w_sh;

   logic [WIDTH:0]   w_madd, w_dsh, w_dsub;
   logic [WIDTH-1:0] w_hi_n, w_lo_n;

   assign in_ready  = en & ((r_state == S_IDLE) |
                            ((r_state == S_DONE) & out_ready));
   assign w_acc     = in_valid & in_ready;
   assign out_valid = (r_state == S_DONE);
   assign result    = r_res;
   assign aux       = r_aux;
   assign flag_z    = r_z;
   assign flag_n    = r_n;
   assign flag_c    = r_c;
   assign flag_v    = r_v;
   assign flag_dz   = r_dz;

   assign w_sh     = b[SHW-1:0];
   assign w_acc_st = (opcode == 4'd14) ? S_MUL :
                     (opcode == 4'd15) ? S_DIV : S_DONE;

   always_comb begin
      w_sum = '0;
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (opcode)
         4'd0: begin
            w_sum = {1'b0, a} + {1'b0, b};
            w_res = w_sum[MSB:0];
            w_c   = w_sum[WIDTH];
            w_v   = (a[MSB] == b[MSB]) & (w_res[MSB] != a[MSB]);
         end
         4'd1: begin
            w_sum = {1'b0, a} - {1'b0, b};
            w_res = w_sum[MSB:0];
            w_c   = w_sum[WIDTH];
            w_v   = (a[MSB] != b[MSB]) & (w_res[MSB] != a[MSB]);
         end
         4'd2:  w_res = a & b;
         4'd3:  w_res = a | b;
         4'd4:  w_res = a ^ b;
         4'd5:  w_res = ~a;
         4'd6:  w_res = ~(a & b);
         4'd7:  w_res = ~(a | b);
         4'd8:  w_res = ~(a ^ b);
         4'd9:  w_res = a << w_sh;
         4'd10: w_res = a >> w_sh;
         4'd11: w_res = $signed(a) >>> w_sh;
         4'd12: begin
            w_sum = {1'b0, a} + 1'b1;
            w_res = w_sum[MSB:0];
            w_c   = w_sum[WIDTH];
            w_v   = ~a[MSB] & w_res[MSB];
         end
         4'd13: begin
            w_sum = {1'b0, a} - 1'b1;
            w_res = w_sum[MSB:0];
            w_c   = w_sum[WIDTH];
            w_v   = a[MSB] & ~w_res[MSB];
         end
         default: ;
      endcase
   end

   // One multiply or divide bit per cycle on the {r_hi, r_lo} pair
   always_comb begin
      w_madd = {1'b0, r_hi} +
               (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
      w_dsh  = {r_hi, r_lo[MSB]};
      w_dsub = w_dsh - {1'b0, r_b};
      w_hi_n = r_hi;
      w_lo_n = r_lo;
      if (r_state == S_MUL) begin
         w_hi_n = w_madd[WIDTH:1];
         w_lo_n = {w_madd[0], r_lo[MSB:1]};
      end else if (r_state == S_DIV) begin
         if (w_dsub[WIDTH]) begin
            w_hi_n = w_dsh[MSB:0];
            w_lo_n = {r_lo[MSB-1:0], 1'b0};
         end else begin
            w_hi_n = w_dsub[MSB:0];
            w_lo_n = {r_lo[MSB-1:0], 1'b1};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_acc) w_next = w_acc_st;
         S_MUL, S_DIV: if (r_cnt == LAST) w_next = S_DONE;
         S_DONE: begin
            if (w_acc)          w_next = w_acc_st;
            else if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_b   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_res <= '0;
         r_aux <= '0;
         r_z   <= 1'b0;
         r_n   <= 1'b0;
         r_c   <= 1'b0;
         r_v   <= 1'b0;
         r_dz  <= 1'b0;
      end else if (w_acc) begin
         r_b   <= b;
         r_hi  <= '0;
         r_lo  <= a;
         r_cnt <= '0;
         if (opcode < 4'd14) begin
            r_res <= w_res;
            r_aux <= '0;
            r_z   <= (w_res == '0);
            r_n   <= w_res[MSB];
            r_c   <= w_c;
            r_v   <= w_v;
            r_dz  <= 1'b0;
         end
      end else if (r_state == S_MUL || r_state == S_DIV) begin
         r_hi  <= w_hi_n;
         r_lo  <= w_lo_n;
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == LAST) begin
            r_res <= w_lo_n;
            r_aux <= w_hi_n;
            r_z   <= (w_lo_n == '0);
            r_n   <= w_lo_n[MSB];
            r_c   <= 1'b0;
            r_v   <= (r_state == S_MUL) & (|w_hi_n);
            r_dz  <= (r_state == S_DIV) & (r_b == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_hs.sv
// Directed bench for alu_seq_hs with a queue scoreboard
// checked by an output monitor.
module tb_alu_seq_hs;

   logic        clk = 1'b0;
   logic        rst, en, in_valid, in_ready;
   logic [15:0] a, b;
   logic [3:0]  opcode;
   logic        out_valid, out_ready;
   logic [15:0] result, aux;
   logic        flag_z, flag_n, flag_c, flag_v, flag_dz;

   typedef struct {
      logic [15:0] res;
      logic [15:0] aux;
      logic        z, n, c, v, dz;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   alu_seq_hs #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .aux(aux),
      .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
      .flag_v(flag_v), .flag_dz(flag_dz)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op,
                                  input logic [15:0] x,
                                  input logic [15:0] y);
      exp_t        e;
      logic [31:0] p;
      logic [3:0]  sh;
      sh = y[3:0];
      e.res = '0; e.aux = '0;
      e.z = 0; e.n = 0; e.c = 0; e.v = 0; e.dz = 0;
      e.acc = 0;
      case (op)
         4'd0: begin
            e.res = x + y;
            e.c   = (32'(x) + 32'(y)) > 32'h0000FFFF;
            e.v   = (x[15] == y[15]) && (e.res[15] != x[15]);
         end
         4'd1: begin
            e.res = x - y;
            e.c   = (x < y);
            e.v   = (x[15] != y[15]) && (e.res[15] != x[15]);
         end
         4'd2:  e.res = x & y;
         4'd3:  e.res = x | y;
         4'd4:  e.res = x ^ y;
         4'd5:  e.res = ~x;
         4'd6:  e.res = ~(x & y);
         4'd7:  e.res = ~(x | y);
         4'd8:  e.res = ~(x ^ y);
         4'd9:  e.res = x << sh;
         4'd10: e.res = x >> sh;
         4'd11: e.res = 16'($signed(x) >>> sh);
         4'd12: begin
            e.res = x + 16'd1;
            e.c   = (x == 16'hFFFF);
            e.v   = (x == 16'h7FFF);
         end
         4'd13: begin
            e.res = x - 16'd1;
            e.c   = (x == 16'h0000);
            e.v   = (x == 16'h8000);
         end
         4'd14: begin
            p     = 32'(x) * 32'(y);
            e.res = p[15:0];
            e.aux = p[31:16];
            e.v   = (e.aux != 0);
         end
         default: begin
            if (y == 0) begin
               e.res = 16'hFFFF;
               e.aux = x;
               e.dz  = 1'b1;
            end else begin
               e.res = x / y;
               e.aux = x % y;
            end
         end
      endcase
      e.z   = (e.res == 0);
      e.n   = e.res[15];
      e.lat = (op >= 4'd14) ? 17 : 1;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 64'(out_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("result", {result, aux, flag_z, flag_n,
                           flag_c, flag_v, flag_dz},
                {e.res, e.aux, e.z, e.n, e.c, e.v, e.dz});
            if (e.lat != 0)
               chk("latency", 64'(cyc + 1 - e.acc), 64'(e.lat));
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [15:0] ia,
                        input logic [15:0] ib, input int lat);
      exp_t e;
      int   t;
      opcode   = op;
      a        = ia;
      b        = ib;
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("accept_op%0d", op), 64'(in_ready), 64'd1);
      if (in_ready) begin
         e     = model(op, ia, ib);
         e.lat = lat;
         e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int c0;
      int seen;
      rst = 1'b1; en = 1'b1; in_valid = 1'b0;
      a = '0; b = '0; opcode = '0; out_ready = 1'b1;
      #12 rst = 1'b0;

      @(posedge clk); #3 rst = 1'b1;
      #1 chk("rst_async", {out_valid, result, aux, flag_z, flag_n,
                           flag_c, flag_v, flag_dz}, 64'd0);
      @(posedge clk); #3 rst = 1'b0;
      #1 chk("rdy_after_rst", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      c0 = cyc;
      for (int op = 0; op < 14; op++)
         issue(4'(op), 16'h0047, 16'h0009, 1);
      chk("sweep_cycles", 64'(cyc - c0), 64'd14);
      issue(4'd14, 16'h0047, 16'h0009, 17);
      issue(4'd15, 16'h0047, 16'h0009, 17);
      drain();

      issue(4'd0, 16'h7FFF, 16'h0001, 1);
      issue(4'd1, 16'h0000, 16'h0001, 1);
      issue(4'd15, 16'h0047, 16'h0000, 17);
      issue(4'd9, 16'h0047, 16'h0010, 1);
      issue(4'd11, 16'h8001, 16'h0003, 1);
      issue(4'd13, 16'h0000, 16'h0000, 1);
      issue(4'd14, 16'hFFFF, 16'hFFFF, 17);
      drain();

      out_ready = 1'b0;
      issue(4'd0, 16'h7FFF, 16'h0001, 0);
      opcode = 4'd1; a = 16'h0000; b = 16'h0001; in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold", {in_ready, out_valid, result, aux, flag_z,
                         flag_n, flag_c, flag_v, flag_dz},
             {1'b0, 1'b1, 16'h8000, 16'h0000, 5'b01010});
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      c0 = cyc;
      issue(4'd1, 16'h0000, 16'h0001, 1);
      chk("bp_release", 64'(cyc - c0), 64'd1);

      @(posedge clk); #1;
      en = 1'b0;
      opcode = 4'd0; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("en_block", {in_ready, out_valid}, 64'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      en = 1'b1;

      issue(4'd14, 16'h0047, 16'h0009, 17);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      sb.delete();
      #1 chk("rst_mid_mul", {out_valid, result, aux, flag_z, flag_n,
                             flag_c, flag_v, flag_dz}, 64'd0);
      @(posedge clk); #3 rst = 1'b0;
      #1 chk("rdy_after_rst2", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      chk("no_out_after_rst", 64'(seen), 64'd0);
      @(posedge clk); #1;
      issue(4'd0, 16'h0047, 16'h0009, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
